receive: RTL and testbench

Instruction-stream receiver directly downstream of the `transmit` stage. It raises the sync request, captures each acknowledged instruction word into a DEPTH-entry local instruction buffer, and terminates on the last-word flag. It then exposes the buffer through a registered read port to the MIPS fetch logic, with a done/error status.

---
 rtl/mips_pkg.sv | 16 +
 rtl/instr_buffer.sv | 42 ++++
 rtl/receive.sv | 84 ++++++++
 tb/tb_receive.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Types and defaults shared by the instruction transmitter and receiver.
package mips_pkg;

  // Receiver control states; the encoding is fixed so that both ends agree.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } rx_state_t;

  // Word width and buffer depth used on both sides of the link.
  localparam int IWIDTH_DEF = 32;
  localparam int DEPTH_DEF  = 7;

endpackage

// File: rtl/instr_buffer.sv
// Local instruction store: DEPTH x IWIDTH registers, cleared on reset,
// one write port and a registered read port returning 0 out of range.
module instr_buffer #(
  parameter int IWIDTH = 32,
  parameter int DEPTH  = 7,
  parameter int AWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [IWIDTH-1:0] wr_data,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [IWIDTH-1:0] rd_data
);

  logic [IWIDTH-1:0] mem [DEPTH];

  // Storage array: wiped on reset so no previous load survives it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register: samples the pre-write contents, so a same-cycle
  // write and read of one address returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (32'(rd_addr) < DEPTH) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/receive.sv
// Instruction-stream receiver: requests words from the transmitter,
// stores each acknowledged word, and exposes the buffer to fetch.
module receive
  import mips_pkg::*;
#(
  parameter int IWIDTH = IWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CWIDTH = $clog2(DEPTH + 1)
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              r_i_start,
  input  logic [IWIDTH-1:0] r_i_instr,
  input  logic              r_i_ack,
  input  logic              r_i_last,
  output logic              r_o_syn,
  input  logic [AWIDTH-1:0] r_i_rd_addr,
  output logic [IWIDTH-1:0] r_o_rd_data,
  output logic [CWIDTH-1:0] r_o_count,
  output logic              r_o_done,
  output logic              r_o_err
);

  rx_state_t         state_q;
  // The stored-word count doubles as the write pointer: both restart at
  // zero together and advance on exactly the same accepted words.
  logic [CWIDTH-1:0] count_q;
  logic              full;
  logic              wr_en;

  assign full  = (32'(count_q) >= DEPTH);
  assign wr_en = (state_q == RECV) && r_i_ack && !full;

  // Load control: start/restart, per-word accept, completion and overflow.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      case (state_q)
        RECV: begin
          if (r_i_ack) begin
            if (!full) begin
              count_q <= count_q + CWIDTH'(1);
              if (r_i_last) begin
                state_q <= DONE;
              end
            end else begin
              state_q <= ERR;
            end
          end
        end
        default: begin
          // IDLE, DONE and ERR all begin a fresh load the same way.
          if (r_i_start) begin
            count_q <= '0;
            state_q <= RECV;
          end
        end
      endcase
    end
  end

  assign r_o_syn   = (state_q == RECV);
  assign r_o_done  = (state_q == DONE);
  assign r_o_err   = (state_q == ERR);
  assign r_o_count = count_q;

  instr_buffer #(
    .IWIDTH (IWIDTH),
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) u_buf (
    .clk     (r_clk),
    .rst     (r_rst),
    .wr_en   (wr_en),
    .wr_addr (count_q[AWIDTH-1:0]),
    .wr_data (r_i_instr),
    .rd_addr (r_i_rd_addr),
    .rd_data (r_o_rd_data)
  );

endmodule

// File: tb/tb_receive.sv
// Bench for receive: stimulus pushes expected post-edge outputs from a
// behavioural model into a queue; a monitor pops and compares each cycle.
module tb_receive;

  localparam int DEPTH = 7;

  logic        t_clk = 1'b0;
  logic        r_rst = 1'b0;
  logic        r_i_start = 1'b0;
  logic [31:0] r_i_instr = '0;
  logic        r_i_ack = 1'b0;
  logic        r_i_last = 1'b0;
  logic [2:0]  r_i_rd_addr = '0;
  logic        r_o_syn;
  logic [31:0] r_o_rd_data;
  logic [2:0]  r_o_count;
  logic        r_o_done;
  logic        r_o_err;

  receive dut (
    .r_clk       (t_clk),
    .r_rst       (r_rst),
    .r_i_start   (r_i_start),
    .r_i_instr   (r_i_instr),
    .r_i_ack     (r_i_ack),
    .r_i_last    (r_i_last),
    .r_o_syn     (r_o_syn),
    .r_i_rd_addr (r_i_rd_addr),
    .r_o_rd_data (r_o_rd_data),
    .r_o_count   (r_o_count),
    .r_o_done    (r_o_done),
    .r_o_err     (r_o_err)
  );

  always #5 t_clk = ~t_clk;

  typedef struct {
    logic        syn;
    logic        done;
    logic        err;
    logic [2:0]  count;
    logic [31:0] rd;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model: stored words, how many, and the outcome of the load.
  logic [31:0] m_mem [DEPTH];
  int          m_n       = 0;
  bit          m_loading = 0;
  bit          m_ok      = 0;
  bit          m_ovf     = 0;
  logic [31:0] rom [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_n = 0; m_loading = 0; m_ok = 0; m_ovf = 0;
  endtask

  // One clock of stimulus; the model predicts outputs after the next edge.
  task automatic drive(input bit st, input bit ack, input bit last,
                       input logic [31:0] w, input int addr);
    exp_t e;
    @(negedge t_clk);
    r_i_start = st; r_i_ack = ack; r_i_last = last; r_i_instr = w;
    r_i_rd_addr = 3'(addr);
    e.rd = (addr < DEPTH) ? m_mem[addr] : 32'h0;
    if (m_loading) begin
      if (ack) begin
        if (m_n < DEPTH) begin
          m_mem[m_n] = w;
          m_n++;
          if (last) begin m_loading = 0; m_ok = 1; end
        end else begin
          m_loading = 0; m_ovf = 1;
        end
      end
    end else if (st) begin
      m_loading = 1; m_ok = 0; m_ovf = 0; m_n = 0;
    end
    e.syn = m_loading; e.done = m_ok; e.err = m_ovf; e.count = 3'(m_n);
    sbq.push_back(e);
  endtask

  task automatic idle(input int addr);
    drive(0, 0, 0, 32'h0, addr);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    @(negedge t_clk);
    r_rst = 1'b1;
    r_i_start = 0; r_i_ack = 0; r_i_last = 0; r_i_instr = '0; r_i_rd_addr = '0;
    #1;
    check("rst_syn",   32'(r_o_syn),   32'h0);
    check("rst_done",  32'(r_o_done),  32'h0);
    check("rst_err",   32'(r_o_err),   32'h0);
    check("rst_count", 32'(r_o_count), 32'h0);
    check("rst_rd",    r_o_rd_data,    32'h0);
    model_clear();
    @(posedge t_clk);
    @(negedge t_clk);
    r_rst = 1'b0;
  endtask

  // Scoreboard monitor: one expected entry per driven cycle.
  initial begin
    forever begin
      exp_t e;
      @(posedge t_clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("syn",   32'(r_o_syn),   32'(e.syn));
        check("done",  32'(r_o_done),  32'(e.done));
        check("err",   32'(r_o_err),   32'(e.err));
        check("count", 32'(r_o_count), 32'(e.count));
        check("rd",    r_o_rd_data,    e.rd);
      end
    end
  end

  initial begin
    model_clear();
    do_reset();
    // Reset contents: every address reads zero, plus one out of range.
    for (int a = 0; a <= DEPTH; a++) idle(a);

    // Transmitter-style load of a full ROM, last flag on the final word.
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
    drive(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < DEPTH; i++) drive(0, 1, (i == DEPTH - 1), rom[i], i);
    for (int a = 0; a < DEPTH; a++) idle(a);

    // Short load of three words after a fresh reset.
    do_reset();
    drive(1, 0, 0, 32'h0, 0);
    drive(0, 1, 0, 32'h11111111, 0);
    drive(0, 1, 0, 32'h22222222, 0);
    drive(0, 1, 1, 32'h33333333, 0);
    idle(2); idle(3); idle(0);

    // Overflow: eight acked words with no last flag.
    drive(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < DEPTH + 1; i++) drive(0, 1, 0, 32'hA0000000 + 32'(i), 6);
    idle(6); idle(5); idle(6);

    // Reset in the middle of a load.
    drive(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, $urandom, 0);
    do_reset();
    for (int a = 0; a < DEPTH; a++) idle(a);

    // Ack in IDLE is ignored; start during RECV is ignored; start from DONE restarts.
    drive(0, 1, 1, 32'hDEADBEEF, 0);
    idle(0);
    drive(1, 0, 0, 32'h0, 0);
    drive(0, 1, 0, 32'hCAFE0001, 0);
    drive(1, 0, 0, 32'h0, 0);
    drive(1, 1, 1, 32'hCAFE0002, 1);
    idle(0); idle(1);
    drive(1, 0, 0, 32'h0, 1);
    idle(1);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 15) == 0), $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0), $urandom, $urandom_range(0, 7));
    end

    repeat (3) @(negedge t_clk);
    check("sb_drained", 32'(sbq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Overall time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d entries pending, expected 0", sbq.size());
    $fatal(1, "timeout");
  end

endmodule
